// File: rtl/shift_pipe_rr_arbiter_if.sv
// Handshake bundle between the producers, the shared pipeline and the consumer.
// The arbiter takes the slave view; the environment (producers plus consumer)
// takes the master view.
interface shift_pipe_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 2
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [IDW-1:0]           out_id;
  logic                     out_ready;
  logic                     busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, busy
  );
endinterface

// File: rtl/shift_pipe_rr_arbiter.sv
// Round-robin arbiter feeding a shared DEPTH-stage shift pipeline.
// Each accepted word carries the id of its requester down the pipe, so the
// consumer can tell who produced it. The whole pipe moves as one unit: it
// advances whenever the last stage is empty or being consumed, and bubbles
// are kept in place rather than squeezed out.
module shift_pipe_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 2,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic                    CLK,
  input logic                    ASYNCRESETN,
  shift_pipe_rr_arbiter_if.slave bus
);

  localparam logic [IDW-1:0]     LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // Pipeline stages: index 0 is the entry stage, DEPTH-1 drives the outputs.
  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [IDW-1:0]   stage_id   [DEPTH];

  // Round-robin pointer: the requester with the highest priority next.
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;

  logic               advance;
  logic               transfer;
  logic [NUM_REQ-1:0] masked_req;
  logic               found_hi;
  logic               found_lo;
  logic [IDW-1:0]     grant_hi;
  logic [IDW-1:0]     grant_lo;
  logic               grant_found;
  logic [IDW-1:0]     grant;
  logic [WIDTH-1:0]   grant_data;

  // The pipe can move when the last stage is empty or the consumer takes it.
  assign advance = !stage_valid[DEPTH-1] || bus.out_ready;

  // Requesters at or above the pointer take precedence over those below it.
  always_comb begin
    masked_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      masked_req[i] = bus.req_valid[i] && (IDW'(i) >= ptr);
    end
  end

  // Two lowest-index scans: one over the upper (masked) set, one over all.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_hi && masked_req[i]) begin
        found_hi = 1'b1;
        grant_hi = IDW'(i);
      end
      if (!found_lo && bus.req_valid[i]) begin
        found_lo = 1'b1;
        grant_lo = IDW'(i);
      end
    end
  end

  assign grant_found = found_hi || found_lo;
  assign grant       = found_hi ? grant_hi : grant_lo;

  // Select the granted requester's data word from the flattened bus.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        grant_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset is folded in so no requester sees an accept while the block is held
  // in reset, even with its valid raised.
  assign transfer      = advance && grant_found && ASYNCRESETN;
  assign bus.req_ready = transfer ? (ONE_HOT0 << grant) : '0;

  assign ptr_next = (grant == LAST_ID) ? '0 : grant + IDW'(1);

  // Shift the whole pipe one step on each advance; the entry stage takes the
  // granted word or a bubble when nobody is requesting.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      stage_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stage_data[i] <= '0;
        stage_id[i]   <= '0;
      end
    end else if (advance) begin
      stage_valid[0] <= transfer;
      stage_data[0]  <= transfer ? grant_data : '0;
      stage_id[0]    <= transfer ? grant : '0;
      for (int i = 1; i < DEPTH; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
        stage_id[i]    <= stage_id[i-1];
      end
    end
  end

  // Move priority to just past the winner; idle cycles leave it alone.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= ptr_next;
    end
  end

  assign bus.out_valid = stage_valid[DEPTH-1];
  assign bus.out_data  = stage_data[DEPTH-1];
  assign bus.out_id    = stage_id[DEPTH-1];
  assign bus.busy      = |stage_valid;

endmodule

// File: tb/tb_shift_pipe_rr_arbiter.sv
// Directed plus randomized bench for shift_pipe_rr_arbiter. A queue-based
// reference model tracks the in-flight words and the rotating priority.
module tb_shift_pipe_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 2;
  localparam int DEPTH   = 2;

  typedef struct {
    bit       v;
    bit [1:0] d;
    bit [1:0] id;
  } word_t;

  logic CLK;
  logic ASYNCRESETN;

  shift_pipe_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  shift_pipe_rr_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .bus         (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  word_t    pipe[$];
  int       m_ptr;
  bit       pend_v [NUM_REQ];
  bit [1:0] pend_d [NUM_REQ];
  bit       ordy;

  logic [3:0] last_ready;
  logic       last_valid;
  logic [1:0] last_data;
  logic [1:0] last_id;
  logic       last_busy;

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    m_ptr = 0;
    pipe.delete();
    for (int j = 0; j < DEPTH; j++) pipe.push_back('{v: 1'b0, d: 2'd0, id: 2'd0});
    for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
  endfunction

  // One clock cycle: drive from the pending table, compare, then step the model.
  task automatic applyStimulus(string tag);
    logic [3:0] rv;
    logic [7:0] rd;
    logic [3:0] exp_ready;
    bit         adv;
    bit         found;
    bit         exp_busy;
    int         g;
    int         idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      rv[i]          = pend_v[i];
      rd[i*2 +: 2]   = pend_d[i];
    end
    bus.req_valid = rv;
    bus.req_data  = rd;
    bus.out_ready = ordy;
    #2;
    adv   = !pipe[DEPTH-1].v || ordy;
    found = 1'b0;
    g     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (m_ptr + k) % NUM_REQ;
      if (!found && pend_v[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    exp_ready = (adv && found) ? (4'b0001 << g) : 4'b0000;
    exp_busy  = 1'b0;
    foreach (pipe[j]) if (pipe[j].v) exp_busy = 1'b1;

    last_ready = bus.req_ready;
    last_valid = bus.out_valid;
    last_data  = bus.out_data;
    last_id    = bus.out_id;
    last_busy  = bus.busy;
    checkOutput({tag, ".req_ready"}, 32'(last_ready), 32'(exp_ready));
    checkOutput({tag, ".out_valid"}, 32'(last_valid), 32'(pipe[DEPTH-1].v));
    checkOutput({tag, ".busy"},      32'(last_busy),  32'(exp_busy));
    if (pipe[DEPTH-1].v) begin
      checkOutput({tag, ".out_data"}, 32'(last_data), 32'(pipe[DEPTH-1].d));
      checkOutput({tag, ".out_id"},   32'(last_id),   32'(pipe[DEPTH-1].id));
    end

    @(posedge CLK);
    if (adv) begin
      void'(pipe.pop_back());
      if (found) pipe.push_front('{v: 1'b1, d: pend_d[g], id: 2'(g)});
      else       pipe.push_front('{v: 1'b0, d: 2'd0, id: 2'd0});
    end
    if (adv && found) begin
      m_ptr     = (g + 1) % NUM_REQ;
      pend_v[g] = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [3:0] onehot;
    logic [1:0] drain_ids [5];

    // 1. reset and idle
    ASYNCRESETN   = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    ordy          = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pend_d[i] = 2'd0;
    modelReset();
    #2 ASYNCRESETN = 1'b0;
    #1;
    checkOutput("rst.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst.out_data",  32'(bus.out_data),  32'd0);
    checkOutput("rst.out_id",    32'(bus.out_id),    32'd0);
    checkOutput("rst.busy",      32'(bus.busy),      32'd0);
    checkOutput("rst.req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #3 ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    ordy = 1'b1;
    repeat (4) applyStimulus("t1_idle");

    // 2. single request from requester 0
    pend_v[0] = 1'b1;
    pend_d[0] = 2'b10;
    applyStimulus("t2_c0");
    checkOutput("t2_grant", 32'(last_ready), 32'b0001);
    applyStimulus("t2_c1");
    applyStimulus("t2_c2");
    checkOutput("t2_lat_valid", 32'(last_valid), 32'd1);
    checkOutput("t2_lat_data",  32'(last_data),  32'b10);
    checkOutput("t2_lat_id",    32'(last_id),    32'd0);

    // bring the pointer back to 0 through requester 3
    pend_v[3] = 1'b1;
    pend_d[3] = 2'd1;
    applyStimulus("t3_prep");
    checkOutput("t3_prep_grant", 32'(last_ready), 32'b1000);

    // 3. all requesters valid, strict rotation
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_v[i]) begin
          pend_v[i] = 1'b1;
          pend_d[i] = 2'(i);
        end
      end
      applyStimulus("t3_rot");
      onehot = 4'b0001 << (k % 4);
      checkOutput("t3_grant", 32'(last_ready), 32'(onehot));
    end

    // 4. stall with a full pipe, then drain in order
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus("t4_stall");
      checkOutput("t4_stall_ready", 32'(last_ready), 32'd0);
      checkOutput("t4_stall_id",    32'(last_id),    32'd2);
      checkOutput("t4_stall_data",  32'(last_data),  32'd2);
    end
    ordy = 1'b1;
    drain_ids[0] = 2'd2;
    drain_ids[1] = 2'd3;
    drain_ids[2] = 2'd0;
    drain_ids[3] = 2'd1;
    drain_ids[4] = 2'd2;
    for (int k = 0; k < 5; k++) begin
      applyStimulus("t4_drain");
      checkOutput("t4_drain_valid", 32'(last_valid), 32'd1);
      checkOutput("t4_drain_id",    32'(last_id),    32'(drain_ids[k]));
    end
    repeat (3) applyStimulus("t4_idle");

    // 5. wrap-around from pointer 3
    pend_v[0] = 1'b1; pend_d[0] = 2'd1;
    pend_v[3] = 1'b1; pend_d[3] = 2'd2;
    applyStimulus("t5_a");
    checkOutput("t5_grant3", 32'(last_ready), 32'b1000);
    applyStimulus("t5_b");
    checkOutput("t5_grant0", 32'(last_ready), 32'b0001);
    pend_v[0] = 1'b1; pend_d[0] = 2'd3;
    pend_v[1] = 1'b1; pend_d[1] = 2'd0;
    applyStimulus("t5_c");
    checkOutput("t5_grant1", 32'(last_ready), 32'b0010);
    repeat (4) applyStimulus("t5_idle");

    // 6. async reset with two words in flight
    pend_v[2] = 1'b1; pend_d[2] = 2'd3;
    applyStimulus("t6_w0");
    pend_v[1] = 1'b1; pend_d[1] = 2'd2;
    applyStimulus("t6_w1");
    bus.req_valid = 4'b1001;
    #2 ASYNCRESETN = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t6_rst_busy",  32'(bus.busy),      32'd0);
    checkOutput("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("t6_hold_valid", 32'(bus.out_valid), 32'd0);
    bus.req_valid = '0;
    #2 ASYNCRESETN = 1'b1;
    modelReset();
    @(posedge CLK);
    #1;
    repeat (3) applyStimulus("t6_idle");
    pend_v[0] = 1'b1; pend_d[0] = 2'd1;
    pend_v[3] = 1'b1; pend_d[3] = 2'd2;
    applyStimulus("t6_first");
    checkOutput("t6_first_grant", 32'(last_ready), 32'b0001);

    // randomized traffic with random back-pressure
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_v[i] && ($urandom_range(0, 1) == 1)) begin
          pend_v[i] = 1'b1;
          pend_d[i] = 2'($urandom_range(0, 3));
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      applyStimulus("rand");
    end
    ordy = 1'b1;
    repeat (10) applyStimulus("drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
